vga_sync_param_core: RTL
========================

// Module: vga_sync_param_core
// PURPOSE
// - Single-clock, timing-parametrised VGA sync core; successor to the dual-clock sync core. Runs entirely at pixel clock.
// - Buffers the pixel stream (bit CD = start-of-frame) in an internal FIFO and generates hsync/vsync.
// - Adds frame resync on SOF, an underflow blank colour, a test pattern and status readback on the video slot bus.
// PARAMETERS
// - CD        12   colour depth; si_data is CD+1 bits, bit CD = SOF
// - HD/HF/HS/HB 640/16/96/48   h display/front porch/sync/back porch (pixels); HT = sum = 800
// - VD/VF/VS/VB 480/10/2/33    v display/front porch/sync/back porch (lines); VT = sum = 525
// - SYNC_POL  0    sync active level (0 = active-low)
// - FIFO_AW   4    FIFO address width; depth 2**FIFO_AW
// PORTS
// - clk        in   1     pixel clock; all logic on rising edge
// - reset      in   1     synchronous, active-low
// - cs, write  in   1     slot select / write strobe
// - addr       in   14    slot address; addr[1:0] decoded, upper bits ignored
// - wr_data    in   32    write data
// - rd_data    out  32    read data (combinational on addr)
// - si_data    in   CD+1  {sof, rgb}
// - si_valid   in   1     upstream word valid
// - si_ready   out  1     FIFO can accept
// - hsync, vsync out 1    sync to monitor
// - rgb        out  CD    pixel to monitor
// - frame_start out 1     1-cycle pulse with first active pixel of every frame
// BEHAVIOUR
// - Regs: 0 CTRL[0]=enable,[1]=test_pat; 1 BLANK[CD-1:0]; 2 STATUS[0]=underflow (sticky, W1C), [1]=synced (RO).
// - Regs are read back zero-extended. Reset: all regs 0.
// - Reset (reset==0 at edge): h_cnt=v_cnt=0; FIFO empty; state UNSYNC.
// - Reset outputs: hsync=vsync=~SYNC_POL, rgb=0, frame_start=0, si_ready=0.
// - enable=0: counters held at 0, syncs inactive, rgb=0, FIFO flushed, si_ready=1 and words discarded, state UNSYNC.
// - Counters: h_cnt 0..HT-1 wraps to 0 and increments v_cnt; v_cnt 0..VT-1 wraps to 0.
// - Active region: h_cnt<HD && v_cnt<VD.
// - hsync active for h_cnt in [HD+HF, HD+HF+HS-1]; vsync active for v_cnt in [VD+VF, VD+VF+VS-1].
// - Outputs are registered: hsync/vsync/rgb/frame_start reflect the counter state of the previous cycle (latency 1).
// - Outside the active region: rgb=0.
// - FIFO: push when si_valid&&si_ready; si_ready = !full. While full, a same-cycle pop does not raise si_ready until the next cycle.
// - Sync FSM:
//   - UNSYNC: pop and discard every head word lacking SOF. When the head has SOF -> WAIT_FRAME (no pop).
//   - WAIT_FRAME: no pops; rgb=BLANK in active region. At h_cnt==0&&v_cnt==0, if head has SOF -> SYNCED and that pixel pops; if empty, stay.
//   - SYNCED: pop one word per active pixel; rgb=head rgb.
//   - SYNCED, head has SOF at an active pixel other than (0,0): no pop, rgb=BLANK -> WAIT_FRAME.
//   - SYNCED, head lacks SOF at (0,0): rgb=BLANK -> UNSYNC.
//   - SYNCED, FIFO empty at an active pixel: rgb=BLANK, set STATUS.underflow, stay SYNCED. Slip is corrected by the SOF checks.
// - frame_start: asserted (with latency 1) on the (0,0) pixel when state goes or stays SYNCED.
// - test_pat=1: rgb = h_cnt[CD-1:0] (zero-extended if CD>bits used) in active region. Stream drained as with enable=0; state UNSYNC. Syncs unchanged.
// - STATUS W1C and a same-cycle underflow event: the set wins.
// - Reset mid-frame: all state returns to reset values on that edge; frame restarts at (0,0).
// TESTING
// - Reset held 3 cycles, enable=0 -> hsync=vsync=1, rgb=0, si_ready=0 during reset; si_ready=1 after.
// - enable=1, test_pat=1 -> hsync low exactly 96 cycles starting at h_cnt 656 (+1 latency); vsync low for lines 490-491; line period 800, frame 420000.
// - Stream a frame of 307200 words with SOF on word 0 -> first active pixel rgb=word0, frame_start one pulse, synced=1, underflow stays 0.
// - Feed 5 junk words then SOF frame -> junk discarded, display locks on next (0,0), synced=1.
// - Stall upstream 10 pixels mid-line -> rgb=BLANK(0xF00) on starved pixels, underflow=1; write 1 to STATUS[0] -> reads 0.
// - Inject SOF at pixel (100,3) -> that pixel BLANK, rest of frame BLANK, resync at next (0,0) with frame_start pulse.

Source files
------------

// File: rtl/vga_sync_param_core.sv
// vga_sync_param_core: single-clock VGA sync core with stream FIFO, SOF frame resync, blank colour, test pattern and status regs
module vga_sync_param_core #(
  parameter int   CD       = 12,
  parameter int   HD       = 640,
  parameter int   HF       = 16,
  parameter int   HS       = 96,
  parameter int   HB       = 48,
  parameter int   VD       = 480,
  parameter int   VF       = 10,
  parameter int   VS       = 2,
  parameter int   VB       = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   FIFO_AW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD:0]   si_data,
  input  logic          si_valid,
  output logic          si_ready,
  output logic          hsync,
  output logic          vsync,
  output logic [CD-1:0] rgb,
  output logic          frame_start
);
  localparam int HT    = HD + HF + HS + HB;
  localparam int VT    = VD + VF + VS + VB;
  localparam int HW    = $clog2(HT);
  localparam int VW    = $clog2(VT);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [1:0] ST_UNSYNC = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SYNCED = 2'd2;
  logic            r_live, r_enable, r_test_pat, r_underflow;
  logic [CD-1:0]   r_blank;
  logic [1:0]      r_state, w_state_nx;
  logic [HW-1:0]   r_h;
  logic [VW-1:0]   r_v;
  logic [CD:0]     r_mem [DEPTH];
  logic [FIFO_AW:0] r_wp, r_rp;
  logic [CD:0]     w_head;
  logic [CD-1:0]   w_rgb;
  logic [CD+HW-1:0] w_hx;
  logic w_drain, w_active, w_origin, w_empty, w_full, w_sof, w_push, w_pop;
  logic w_uf, w_fs, w_hs, w_vs, w_wr, w_unused;
  assign w_wr     = cs && write;
  assign w_drain  = !r_enable || r_test_pat;
  assign w_active = r_h < HW'(HD) && r_v < VW'(VD);
  assign w_origin = r_h == '0 && r_v == '0;
  assign w_empty  = r_wp == r_rp;
  assign w_full   = r_wp == {~r_rp[FIFO_AW], r_rp[FIFO_AW-1:0]};
  assign w_head   = r_mem[r_rp[FIFO_AW-1:0]];
  assign w_sof    = !w_empty && w_head[CD];
  assign si_ready = r_live && (w_drain || !w_full);
  assign w_push   = si_valid && si_ready && !w_drain;
  assign w_hx     = {{CD{1'b0}}, r_h};
  assign w_hs     = r_enable && r_h >= HW'(HD + HF) && r_h <= HW'(HD + HF + HS - 1);
  assign w_vs     = r_enable && r_v >= VW'(VD + VF) && r_v <= VW'(VD + VF + VS - 1);
  assign w_unused = ^{addr, wr_data};
  assign rd_data  = addr[1:0] == 2'd0 ? {30'd0, r_test_pat, r_enable} :
                    addr[1:0] == 2'd1 ? 32'(r_blank) :
                    addr[1:0] == 2'd2 ? {30'd0, r_state == ST_SYNCED, r_underflow} : '0;
  // Only active pixels consume words once locked; UNSYNC discards everything up to the next SOF.
  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_uf       = 1'b0;
    w_fs       = 1'b0;
    w_rgb      = '0;
    if (w_drain) begin
      w_state_nx = ST_UNSYNC;
      w_rgb      = (r_enable && w_active) ? w_hx[CD-1:0] : '0;
    end else if (r_state == ST_UNSYNC) begin
      w_rgb      = w_active ? r_blank : '0;
      w_state_nx = w_sof ? ST_WAIT : ST_UNSYNC;
      w_pop      = !w_empty && !w_sof;
    end else if (w_active && r_state == ST_WAIT) begin
      w_pop      = w_origin && w_sof;
      w_rgb      = w_pop ? w_head[CD-1:0] : r_blank;
      w_state_nx = w_pop ? ST_SYNCED : ST_WAIT;
      w_fs       = w_pop;
    end else if (w_active) begin
      w_uf       = w_empty;
      w_pop      = !w_empty && (w_origin == w_sof);
      w_rgb      = w_pop ? w_head[CD-1:0] : r_blank;
      w_state_nx = (w_empty || w_pop) ? ST_SYNCED : (w_origin ? ST_UNSYNC : ST_WAIT);
      w_fs       = w_origin && (w_empty || w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_live      <= 1'b0;
      r_enable    <= 1'b0;
      r_test_pat  <= 1'b0;
      r_blank     <= '0;
      r_underflow <= 1'b0;
      r_state     <= ST_UNSYNC;
      r_h         <= '0;
      r_v         <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_state     <= w_state_nx;
      r_underflow <= w_uf || (r_underflow && !(w_wr && addr[1:0] == 2'd2 && wr_data[0]));
      if (w_wr && addr[1:0] == 2'd0) begin
        r_enable   <= wr_data[0];
        r_test_pat <= wr_data[1];
      end
      if (w_wr && addr[1:0] == 2'd1) r_blank <= wr_data[CD-1:0];
      if (!r_enable) begin
        r_h <= '0;
        r_v <= '0;
      end else if (r_h == HW'(HT - 1)) begin
        r_h <= '0;
        r_v <= (r_v == VW'(VT - 1)) ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
      if (w_drain) begin
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + (FIFO_AW+1)'(1);
        if (w_pop) r_rp <= r_rp + (FIFO_AW+1)'(1);
      end
      hsync       <= w_hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= w_vs ? SYNC_POL : ~SYNC_POL;
      rgb         <= w_rgb;
      frame_start <= w_fs;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[FIFO_AW-1:0]] <= si_data;
  end
endmodule
